// File: rtl/pixel_distributor.sv
// pixel_distributor: walks a frame in raster order and issues each coordinate
// round-robin to an idle engine whose reorder queue has room.
module pixel_distributor #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_ENGINES = 4,
   parameter int ENG_IDX_W   = 2,
   parameter int X_SIZE      = 640,
   parameter int Y_SIZE      = 480
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_ENGINES-1:0] fin_flag,
   input  logic [NUM_ENGINES-1:0] full_queue,
   output logic [NUM_ENGINES-1:0] eng_start,
   output logic [DATA_WIDTH-1:0]  xpixel_o,
   output logic [DATA_WIDTH-1:0]  ypixel_o,
   output logic                   busy,
   output logic                   frame_done
);
   localparam int SW = ENG_IDX_W + 1;
   localparam logic [SW-1:0] NE = SW'(NUM_ENGINES);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   state_t state;
   logic [NUM_ENGINES-1:0] claimed, elig, rot, pick;
   logic [ENG_IDX_W-1:0] rr_ptr, off, idx, rr_next;
   logic [SW-1:0] sum, inc;
   logic [DATA_WIDTH-1:0] x, y;
   logic found, last_x, last_y;
   // rotate eligibility so bit 0 is rr_ptr, then take the lowest set bit
   always_comb begin
      elig = ~claimed & ~full_queue;
      rot = NUM_ENGINES'({elig, elig} >> rr_ptr);
      found = 1'b0;
      off = '0;
      for (int i = NUM_ENGINES - 1; i >= 0; i--)
         if (rot[i]) begin
            found = 1'b1;
            off = ENG_IDX_W'(i);
         end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      idx = ENG_IDX_W'(sum >= NE ? sum - NE : sum);
      inc = {1'b0, idx} + SW'(1);
      rr_next = ENG_IDX_W'(inc == NE ? '0 : inc);
      pick = found ? NUM_ENGINES'(1) << idx : '0;
      last_x = x == DATA_WIDTH'(X_SIZE - 1);
      last_y = y == DATA_WIDTH'(Y_SIZE - 1);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         eng_start  <= '0;
         xpixel_o   <= '0;
         ypixel_o   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         claimed    <= '0;
         rr_ptr     <= '0;
         x          <= '0;
         y          <= '0;
      end else begin
         eng_start  <= '0;
         frame_done <= 1'b0;
         claimed    <= (claimed & ~fin_flag) | (state == SCAN ? pick : '0);
         case (state)
            IDLE:
               if (start) begin
                  state  <= SCAN;
                  busy   <= 1'b1;
                  x      <= '0;
                  y      <= '0;
                  rr_ptr <= '0;
               end
            SCAN:
               if (found) begin
                  eng_start <= pick;
                  xpixel_o  <= x;
                  ypixel_o  <= y;
                  rr_ptr    <= rr_next;
                  x         <= last_x ? '0 : x + DATA_WIDTH'(1);
                  y         <= last_x ? (last_y ? '0 : y + DATA_WIDTH'(1)) : y;
                  if (last_x && last_y)
                     state <= DRAIN;
               end
            DRAIN:
               if (claimed == '0) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_pixel_distributor.sv
// tb_pixel_distributor: randomized frames against a frame-level scheduling model;
// expected issues/frame_done are queued with their cycle and checked by a monitor.
module tb_pixel_distributor;
   localparam int N = 4, XS = 4, YS = 2, DW = 32, IW = 2, NF = 25;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [N-1:0] fin_flag = '0, full_queue = '0, eng_start;
   logic [DW-1:0] xpixel_o, ypixel_o;
   logic busy, frame_done;

   pixel_distributor #(.DATA_WIDTH(DW), .NUM_ENGINES(N), .ENG_IDX_W(IW), .X_SIZE(XS), .Y_SIZE(YS)) dut (
      .clk(clk), .reset(reset), .start(start), .fin_flag(fin_flag), .full_queue(full_queue),
      .eng_start(eng_start), .xpixel_o(xpixel_o), .ypixel_o(ypixel_o), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int eng; int x; int y;} iss_t;
   iss_t iq[$];
   int dq[$];
   bit exp_busy[int];
   int cyc = 0, checks = 0, passes = 0;
   bit run = 0;

   // frame model: phase 0 idle, 1 scanning, 2 draining, 3 done
   int phase = 0, rr = 0, n = 0;
   bit [N-1:0] mcl = '0, fixfull = '0;
   int fin_at[N];
   int dly[N];
   bit rnd = 0, noise = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input string msg);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: %s", name, msg);
   endtask

   always @(negedge clk) begin
      iss_t e;
      int d;
      if (run) begin
         while (iq.size() > 0 && iq[0].cyc < cyc) begin
            e = iq.pop_front();
            chk(0, "missed_issue", $sformatf("no eng_start in cycle %0d, required e%0d (%0d,%0d)", e.cyc, e.eng, e.x, e.y));
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            d = dq.pop_front();
            chk(0, "missed_done", $sformatf("frame_done low in cycle %0d, required high", d));
         end
         if (eng_start != '0) begin
            if (iq.size() == 0)
               chk(0, "spurious_issue", $sformatf("cycle %0d got eng_start=%b (%0d,%0d), required none", cyc, eng_start, xpixel_o, ypixel_o));
            else begin
               e = iq.pop_front();
               chk(e.cyc == cyc && eng_start == N'(1 << e.eng) && xpixel_o == e.x && ypixel_o == e.y, "issue",
                   $sformatf("cycle %0d got eng_start=%b (%0d,%0d), required cycle %0d e%0d (%0d,%0d)",
                             cyc, eng_start, xpixel_o, ypixel_o, e.cyc, e.eng, e.x, e.y));
            end
         end
         if (frame_done) begin
            if (dq.size() == 0)
               chk(0, "spurious_done", $sformatf("frame_done high in cycle %0d, required low", cyc));
            else begin
               d = dq.pop_front();
               chk(d == cyc, "frame_done", $sformatf("high in cycle %0d, required cycle %0d", cyc, d));
            end
         end
         if (exp_busy.exists(cyc)) begin
            chk(busy == exp_busy[cyc], "busy", $sformatf("cycle %0d got %0b, required %0b", cyc, busy, exp_busy[cyc]));
            exp_busy.delete(cyc);
         end
      end
   end

   task automatic step(input bit st);
      bit [N-1:0] f, fl, pk;
      int k;
      @(negedge clk);
      f = '0;
      for (int j = 0; j < N; j++)
         if (fin_at[j] == cyc) begin
            f[j] = 1'b1;
            fin_at[j] = -1;
         end else if (noise && !mcl[j] && $urandom_range(0, 7) == 0)
            f[j] = 1'b1;
      fl = fixfull | (rnd ? N'($urandom) & N'($urandom) : '0);
      fin_flag = f;
      full_queue = fl;
      start = st;
      pk = '0;
      case (phase)
         0: if (st) begin phase = 1; rr = 0; n = 0; end
         1: for (int i = 0; i < N; i++) begin
               k = (rr + i) % N;
               if (!mcl[k] && !fl[k]) begin
                  pk[k] = 1'b1;
                  iq.push_back('{cyc + 1, k, n % XS, n / XS});
                  fin_at[k] = cyc + 1 + (rnd ? int'($urandom_range(1, 8)) : dly[k]);
                  rr = (k + 1) % N;
                  n++;
                  if (n == XS * YS) phase = 2;
                  break;
               end
            end
         2: if (mcl == '0) begin phase = 3; dq.push_back(cyc + 1); end
         default: phase = 0;
      endcase
      mcl = (mcl & ~f) | pk;
      exp_busy[cyc + 1] = phase != 0;
   endtask

   task automatic frame(input int f);
      rnd = f >= 3;
      noise = f >= 3;
      fixfull = f == 1 ? N'(2) : '0;
      if (f == 2) dly = '{20, 20, 20, 10};
      else dly = '{3, 3, 3, 3};
      if (f >= 2) repeat ($urandom_range(0, 3)) step(0);
      step(1);
      while (phase != 0) step(f >= 2 && $urandom_range(0, 5) == 0);
   endtask

   initial begin
      for (int j = 0; j < N; j++) fin_at[j] = -1;
      repeat (3) @(negedge clk);
      chk(eng_start == '0 && xpixel_o == '0 && ypixel_o == '0 && !busy && !frame_done, "reset_values",
          $sformatf("eng_start=%b x=%0d y=%0d busy=%0b done=%0b, required all 0", eng_start, xpixel_o, ypixel_o, busy, frame_done));
      reset = 1'b0;
      run = 1'b1;
      repeat (3) step(0);
      for (int f = 0; f < NF; f++) frame(f);
      rnd = 0;
      noise = 0;
      fixfull = '0;
      dly = '{3, 3, 3, 3};
      step(1);
      repeat (3) step(0);
      run = 1'b0;
      #1 reset = 1'b1;
      #1 chk(eng_start == '0 && xpixel_o == '0 && ypixel_o == '0 && !busy && !frame_done, "async_reset",
             $sformatf("eng_start=%b x=%0d y=%0d busy=%0b done=%0b, required all 0", eng_start, xpixel_o, ypixel_o, busy, frame_done));
      iq.delete();
      dq.delete();
      exp_busy.delete();
      mcl = '0;
      phase = 0;
      for (int j = 0; j < N; j++) fin_at[j] = -1;
      fin_flag = '0;
      full_queue = '0;
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run = 1'b1;
      repeat (5) step(0);
      frame(NF);
      repeat (3) step(0);
      run = 1'b0;
      chk(iq.size() == 0 && dq.size() == 0, "leftover",
          $sformatf("%0d issues and %0d frame_done still pending, required 0", iq.size(), dq.size()));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
